// File: rtl/fifo_udp_burst_reader.sv
// Read-side consumer for the camera FIFO: launches one UDP packet per PKT_LEN bytes,
// drains the FIFO on UDP byte requests, and flushes a short remainder after frame_end.
module fifo_udp_burst_reader #(
    parameter int RD_DEPTH_WIDTH = 11,
    parameter int PKT_LEN        = 1024,
    parameter int GAP_CYCLES     = 16
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic [RD_DEPTH_WIDTH:0] rd_water_level,
    input  logic                    rempty,
    input  logic [7:0]              rd_data,
    output logic                    r_en,
    input  logic                    frame_end,
    output logic                    tx_start_en,
    output logic [15:0]             tx_byte_num,
    input  logic                    tx_req,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    err_underflow,
    output logic [15:0]             pkt_cnt
);
    localparam int CW = RD_DEPTH_WIDTH + 1;
    localparam logic [CW-1:0] FULL_LEN = CW'(PKT_LEN);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   len_reg, len_next;
    logic [CW-1:0]   byte_cnt_reg, byte_cnt_next;
    logic            flush_pend_reg, flush_pend_next;
    logic            is_flush_reg, is_flush_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic            err_reg, err_next;
    logic [15:0]     pkt_cnt_reg, pkt_cnt_next;
    logic            bytes_left;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            byte_cnt_reg   <= '0;
            flush_pend_reg <= 1'b0;
            is_flush_reg   <= 1'b0;
            gap_cnt_reg    <= '0;
            err_reg        <= 1'b0;
            pkt_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            byte_cnt_reg   <= byte_cnt_next;
            flush_pend_reg <= flush_pend_next;
            is_flush_reg   <= is_flush_next;
            gap_cnt_reg    <= gap_cnt_next;
            err_reg        <= err_next;
            pkt_cnt_reg    <= pkt_cnt_next;
        end
    end

    assign bytes_left = (byte_cnt_reg < len_reg);

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        byte_cnt_next   = byte_cnt_reg;
        flush_pend_next = flush_pend_reg;
        is_flush_next   = is_flush_reg;
        gap_cnt_next    = gap_cnt_reg;
        err_next        = err_reg;
        pkt_cnt_next    = pkt_cnt_reg;
        r_en            = 1'b0;
        tx_start_en     = 1'b0;

        case (state_reg)
            IDLE: begin
                // A full payload always takes priority; the flush stays pending behind it.
                if (rd_water_level >= FULL_LEN) begin
                    len_next      = FULL_LEN;
                    is_flush_next = 1'b0;
                    state_next    = START;
                end else if (flush_pend_reg && (rd_water_level != '0)) begin
                    len_next      = rd_water_level;
                    is_flush_next = 1'b1;
                    state_next    = START;
                end else if (flush_pend_reg) begin
                    flush_pend_next = 1'b0;
                end
            end
            START: begin
                tx_start_en   = 1'b1;
                byte_cnt_next = '0;
                state_next    = SEND;
            end
            SEND: begin
                r_en = tx_req & ~rempty & bytes_left;
                if (r_en)
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                if (tx_req && rempty && bytes_left)
                    err_next = 1'b1;
                if (tx_done) begin
                    pkt_cnt_next = pkt_cnt_reg + 16'd1;
                    gap_cnt_next = '0;
                    if (is_flush_reg)
                        flush_pend_next = 1'b0;
                    if (GAP_CYCLES == 0)
                        state_next = IDLE;
                    else
                        state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST)
                    state_next = IDLE;
                else
                    gap_cnt_next = gap_cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // A new frame end overrides any clear in the same cycle.
        if (frame_end)
            flush_pend_next = 1'b1;
    end

    assign tx_byte_num   = 16'(len_reg);
    assign tx_data       = rd_data;
    assign busy          = (state_reg != IDLE);
    assign err_underflow = err_reg;
    assign pkt_cnt       = pkt_cnt_reg;

endmodule

// File: tb/tb_fifo_udp_burst_reader.sv
// Directed bench: behavioural FIFO and UDP TX stand-ins around fifo_udp_burst_reader.
module tb_fifo_udp_burst_reader;
    logic        rclk = 1'b0;
    logic        rrst_n;
    logic [11:0] rd_water_level;
    logic        rempty;
    logic [7:0]  rd_data;
    logic        r_en;
    logic        frame_end;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        err_underflow;
    logic [15:0] pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 rclk = ~rclk;

    fifo_udp_burst_reader #(
        .RD_DEPTH_WIDTH(11),
        .PKT_LEN(1024),
        .GAP_CYCLES(16)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .rd_water_level(rd_water_level),
        .rempty(rempty),
        .rd_data(rd_data),
        .r_en(r_en),
        .frame_end(frame_end),
        .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num),
        .tx_req(tx_req),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .busy(busy),
        .err_underflow(err_underflow),
        .pkt_cnt(pkt_cnt)
    );

    // FIFO stand-in: writes an incrementing byte pattern, registered read data.
    logic        wr_en;
    logic        force_empty;
    logic [7:0]  mem [0:4095];
    logic [11:0] wptr, rptr;
    logic [12:0] count;
    logic [7:0]  wr_seq;

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            wr_seq  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wr_seq;
                wptr      <= wptr + 12'd1;
                wr_seq    <= wr_seq + 8'd1;
            end
            if (r_en) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + 12'd1;
            end
            count <= count + 13'(wr_en) - 13'(r_en);
        end
    end

    assign rd_water_level = count[11:0];
    assign rempty         = (count == 13'd0) || force_empty;

    // Observer: counts start pulses and reads, checks the byte order on tx_data.
    int          start_cnt = 0;
    int          rd_cnt    = 0;
    int          data_bad  = 0;
    logic [15:0] last_byte_num = '0;
    logic        prev_ren  = 1'b0;
    logic [7:0]  rd_seq    = '0;

    always @(negedge rclk) begin
        if (!rrst_n) begin
            prev_ren = 1'b0;
            rd_seq   = '0;
        end else begin
            if (prev_ren) begin
                if (tx_data !== rd_seq)
                    data_bad++;
                rd_seq = rd_seq + 8'd1;
            end
            prev_ren = r_en;
            if (r_en)
                rd_cnt++;
            if (tx_start_en) begin
                start_cnt++;
                last_byte_num = tx_byte_num;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic fill(input int n);
        repeat (n) begin
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_start(input int s0, input int exp_len, input string tag);
        int t = 0;
        while (start_cnt == s0 && t < 5000) begin
            tick();
            t++;
        end
        check({tag, "_start_seen"}, 32'(start_cnt - s0), 32'd1);
        check({tag, "_byte_num"}, 32'(last_byte_num), 32'(exp_len));
    endtask

    task automatic serve(input int len, input int extra, input string tag);
        int          r0 = rd_cnt;
        int          d0 = data_bad;
        logic [15:0] p0 = pkt_cnt;
        logic        extra_rd = 1'b0;
        repeat (len) begin
            tx_req = 1'b1;
            tick();
        end
        repeat (extra) begin
            tx_req = 1'b1;
            #3;
            if (r_en)
                extra_rd = 1'b1;
            tick();
        end
        tx_req = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, "_reads"}, 32'(rd_cnt - r0), 32'(len));
        check({tag, "_data_order_errs"}, 32'(data_bad - d0), 32'd0);
        if (extra > 0)
            check({tag, "_extra_req_reads"}, 32'(extra_rd), 32'd0);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(p0 + 16'd1));
        check({tag, "_busy_gap_start"}, 32'(busy), 32'd1);
        repeat (15) tick();
        check({tag, "_busy_gap_end"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_idle_after_gap"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   s0;
        logic busy_seen;

        rrst_n      = 1'b0;
        wr_en       = 1'b0;
        force_empty = 1'b0;
        frame_end   = 1'b0;
        tx_req      = 1'b0;
        tx_done     = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        check("rst_r_en", 32'(r_en), 32'd0);
        check("rst_tx_start_en", 32'(tx_start_en), 32'd0);
        check("rst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rrst_n = 1'b1;
        tick();

        // Full packet, plus 5 over-requests once byte_cnt == len.
        s0 = start_cnt;
        fill(1024);
        wait_start(s0, 1024, "full");
        serve(1024, 5, "full");
        check("full_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("full_no_err", 32'(err_underflow), 32'd0);
        $display("full packet: pkt_cnt=%0d err=%0d", pkt_cnt, err_underflow);

        // Flush of a 300-byte remainder.
        s0 = start_cnt;
        fill(300);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        wait_start(s0, 300, "flush");
        serve(300, 0, "flush");
        s0 = start_cnt;
        repeat (50) tick();
        check("flush_no_restart", 32'(start_cnt - s0), 32'd0);
        check("flush_pkt_cnt", 32'(pkt_cnt), 32'd2);
        $display("flush packet: pkt_cnt=%0d", pkt_cnt);

        // One byte short of the threshold: nothing may start.
        s0 = start_cnt;
        fill(1023);
        busy_seen = 1'b0;
        repeat (10000) begin
            busy_seen = busy_seen | busy;
            tick();
        end
        check("below_no_start", 32'(start_cnt - s0), 32'd0);
        check("below_busy", 32'(busy_seen), 32'd0);
        $display("below threshold: starts=%0d busy_seen=%0d", start_cnt - s0, busy_seen);

        // 2048+100 buffered, frame_end during the first SEND.
        s0 = start_cnt;
        fill(1125);
        check("mid_in_send", 32'(busy), 32'd1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        wait_start(s0, 1024, "mid1");
        serve(1024, 0, "mid1");
        s0 = start_cnt;
        wait_start(s0, 1024, "mid2");
        serve(1024, 0, "mid2");
        s0 = start_cnt;
        wait_start(s0, 100, "mid3");
        serve(100, 0, "mid3");
        check("mid_pkt_cnt", 32'(pkt_cnt), 32'd5);
        check("mid_fifo_drained", 32'(rd_water_level), 32'd0);
        $display("frame_end mid-packet: pkt_cnt=%0d", pkt_cnt);

        // Underflow: request while the FIFO claims empty.
        s0 = start_cnt;
        fill(1024);
        wait_start(s0, 1024, "uflow");
        force_empty = 1'b1;
        tx_req      = 1'b1;
        #2;
        check("uflow_r_en", 32'(r_en), 32'd0);
        tick();
        check("uflow_err_set", 32'(err_underflow), 32'd1);
        tx_req      = 1'b0;
        force_empty = 1'b0;
        serve(1024, 0, "uflow");
        check("uflow_err_sticky", 32'(err_underflow), 32'd1);
        $display("underflow: err=%0d pkt_cnt=%0d", err_underflow, pkt_cnt);

        // Asynchronous reset in the middle of a packet.
        s0 = start_cnt;
        fill(1024);
        wait_start(s0, 1024, "rst");
        repeat (500) begin
            tx_req = 1'b1;
            tick();
        end
        #2;
        rrst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_r_en", 32'(r_en), 32'd0);
        check("arst_tx_start_en", 32'(tx_start_en), 32'd0);
        check("arst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("arst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("arst_err", 32'(err_underflow), 32'd0);
        tx_req = 1'b0;
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
        s0 = start_cnt;
        fill(1024);
        wait_start(s0, 1024, "post_rst");
        serve(1024, 0, "post_rst");
        check("post_rst_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("post_rst_err", 32'(err_underflow), 32'd0);
        $display("reset mid-send: pkt_cnt=%0d err=%0d", pkt_cnt, err_underflow);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
